sd_rom_loader: RTL and testbench
================================

SD_ROM_LOADER -- requirements
Module: sd_rom_loader

Interface
REQ-001 Parameter ADDR_W, default 14, sets the cartridge RAM byte-address width.
REQ-002 Parameter INIT_TOUT, default 2^20, is the maximum number of cycles spent waiting for card initialisation.
REQ-003 clk  in  1  system clock. This is the single clock; all logic is on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high; also routed to the SD reader's restart input.
REQ-005 start  in  1  one-cycle load request.
REQ-006 base_sector  in  32  first SD sector of the image.
REQ-007 num_sectors  in  8  number of 512-byte sectors to load.
REQ-008 sd_busy  in  1  SD reader busy flag.
REQ-009 sd_initialized  in  1  SD reader init-OK flag.
REQ-010 sd_data  in  8  SD reader byte output.
REQ-011 sd_wr_n  in  1  SD reader byte strobe, active-low, one cycle per byte.
REQ-012 sd_sector_addr  out  32  sector to read.
REQ-013 sd_start_read  out  1  read request pulse.
REQ-014 ram_addr  out  ADDR_W  cartridge RAM write address.
REQ-015 ram_data  out  8  cartridge RAM write data.
REQ-016 ram_we  out  1  cartridge RAM write enable, one-cycle pulse.
REQ-017 loading  out  1  load in progress.
REQ-018 done  out  1  load completed OK; sticky until next start or rst.
REQ-019 error_code  out  2  error status: 00 none, 01 init timeout/failure, 10 read failure, 11 short sector.
REQ-020 checksum  out  8  running 8-bit sum of loaded bytes.

Function
REQ-021 The FSM SHALL have states IDLE, WAIT_INIT, ISSUE, WAIT_ACK, STREAM, NEXT, DONE and FAIL.
REQ-022 In IDLE, start=1 SHALL:
- latch base_sector and num_sectors;
- clear done, error_code, checksum, sector index and byte index;
- set loading=1;
- go to DONE if num_sectors==0, else to WAIT_INIT.
REQ-023 start SHALL be ignored in every state other than IDLE and DONE/FAIL; in DONE/FAIL it behaves as in IDLE.
REQ-024 WAIT_INIT SHALL go to ISSUE when sd_initialized=1 and sd_busy=0.
REQ-025 WAIT_INIT SHALL go to FAIL with code 01 when sd_busy=0 and sd_initialized=0, or when INIT_TOUT cycles elapse.
REQ-026 ISSUE SHALL drive sd_sector_addr = latched base + sector index (32-bit, wraps modulo 2^32) and assert sd_start_read for exactly one cycle, then go to WAIT_ACK.
REQ-027 sd_sector_addr SHALL hold stable from ISSUE until the read ends.
REQ-028 WAIT_ACK SHALL go to STREAM on the first cycle with sd_busy=1.
REQ-029 WAIT_ACK SHALL go to FAIL with code 10 after 16 cycles without sd_busy=1.
REQ-030 In STREAM, each cycle with sd_wr_n=0 while sd_wr_n was 1 in the previous cycle SHALL produce, on the next cycle:
- ram_we=1;
- ram_data = sd_data;
- ram_addr = (sector index*512 + byte index) mod 2^ADDR_W;
- byte index incremented by 1.
REQ-031 Strobe-to-ram_we latency SHALL be exactly 1 cycle.
REQ-032 Address wrap beyond 2^ADDR_W SHALL NOT be an error.
REQ-033 Strobes while the byte index is already 512 SHALL be dropped.
REQ-034 When sd_busy falls in STREAM, the FSM SHALL decide on the same cycle:
- sd_initialized=0 -> FAIL with code 10;
- byte index != 512 -> FAIL with code 11;
- otherwise -> NEXT.
REQ-035 A strobe coinciding with the busy fall SHALL still be written before the decision.
REQ-036 NEXT SHALL:
- increment the sector index and clear the byte index;
- go to DONE if the sector index now equals num_sectors, else to ISSUE.
REQ-037 ISSUE SHALL NOT pulse sd_start_read until sd_busy=0.
REQ-038 DONE SHALL set done=1 and loading=0.
REQ-039 FAIL SHALL set loading=0, hold error_code, and keep done=0.

Reset
REQ-040 On rst=1 at any clock edge, including mid-sector, the block SHALL:
- set state=IDLE;
- drive sd_start_read=0, ram_we=0, loading=0, done=0, error_code=00, checksum=00, ram_addr=0, ram_data=0 and sd_sector_addr=0;
- clear all counters.
REQ-041 After reset, any in-flight sector SHALL be discarded and no further ram_we SHALL occur.

Configuration
REQ-042 With macro SD_LOADER_CHECKSUM_EN defined, checksum SHALL add ram_data modulo 256 on every ram_we.
REQ-043 Without SD_LOADER_CHECKSUM_EN, checksum SHALL be a constant 8'h00 and no adder SHALL be synthesised.

Structure
REQ-044 FSM state encodings, error-code constants and SECTOR_BYTES=512 SHALL live in the shared package sd_loader_pkg.
REQ-045 One sub-module, sd_strobe_edge (falling-edge detector with a 1-cycle registered data capture), SHALL be instantiated once.

Verification
REQ-046 Load 2 sectors: base=0x100, num=2, 1024 strobes with data=addr[7:0] -> sd_start_read pulses with addr 0x100 then 0x101, ram_addr 0..1023, done=1, error_code=00.
REQ-047 num_sectors=0 -> done=1 within 2 cycles of start, with no sd_start_read.
REQ-048 sd_busy=0 and sd_initialized=0 in WAIT_INIT -> error_code=01, loading=0.
REQ-049 Busy falls after 300 strobes -> error_code=11, with exactly 300 ram_we pulses.
REQ-050 rst asserted after 100 bytes -> all outputs at reset values next cycle, and no ram_we afterwards.
REQ-051 With SD_LOADER_CHECKSUM_EN, 512 bytes of 0x01 -> checksum=0x00 (512 mod 256); with bytes 0x00..0xFF twice -> checksum=0x00; with a single sector of 0x03 bytes -> checksum=0x00; with num=1 and data 0xFF only in byte 0 -> checksum=0xFF.

Source files
------------

// File: rtl/sd_loader_pkg.sv
// Shared definitions for the SD-card ROM loader: FSM states, error codes
// and sector geometry.
package sd_loader_pkg;

   localparam int SECTOR_BYTES = 512;
   localparam int BYTE_IDX_W   = 10;
   localparam int ACK_TOUT     = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_INIT,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_STREAM,
      ST_NEXT,
      ST_DONE,
      ST_FAIL
   } state_t;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_INIT  = 2'b01;
   localparam logic [1:0] ERR_READ  = 2'b10;
   localparam logic [1:0] ERR_SHORT = 2'b11;

endpackage

// File: rtl/sd_strobe_edge.sv
// Falling-edge detector for the SD reader's active-low byte strobe, with a
// one-cycle registered capture of the accompanying data byte.
module sd_strobe_edge (
   input  logic       clk,
   input  logic       rst,
   input  logic       strobe_n,
   input  logic       enable,
   input  logic [7:0] data_in,
   output logic       fall,
   output logic       pulse,
   output logic [7:0] data_q
);

   logic strobe_n_prev;

   assign fall = strobe_n_prev & ~strobe_n;

   // Remember last strobe level; register an accepted edge and its byte
   always_ff @(posedge clk) begin
      if (rst) begin
         strobe_n_prev <= 1'b1;
         pulse         <= 1'b0;
         data_q        <= 8'h00;
      end else begin
         strobe_n_prev <= strobe_n;
         pulse         <= fall & enable;
         if (fall & enable) begin
            data_q <= data_in;
         end
      end
   end

endmodule

// File: rtl/sd_rom_loader.sv
// Loads a run of 512-byte SD sectors into cartridge RAM.
// Optional feature: define SD_LOADER_CHECKSUM_EN to enable the running
// 8-bit checksum of written bytes; otherwise checksum reads as 8'h00.
// ADDR_W is assumed to be at most 32.
module sd_rom_loader
   import sd_loader_pkg::*;
#(
   parameter int ADDR_W    = 14,
   parameter int INIT_TOUT = 1 << 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       base_sector,
   input  logic [7:0]        num_sectors,
   input  logic              sd_busy,
   input  logic              sd_initialized,
   input  logic [7:0]        sd_data,
   input  logic              sd_wr_n,
   output logic [31:0]       sd_sector_addr,
   output logic              sd_start_read,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_data,
   output logic              ram_we,
   output logic              loading,
   output logic              done,
   output logic [1:0]        error_code,
   output logic [7:0]        checksum
);

   localparam int TMR_W = ($clog2(INIT_TOUT + 1) > 5) ? $clog2(INIT_TOUT + 1) : 5;

   state_t                state, state_d;
   logic [31:0]           base_q;
   logic [7:0]            num_q;
   logic [7:0]            sec_idx;
   logic [BYTE_IDX_W-1:0] byte_idx;
   logic [BYTE_IDX_W-1:0] byte_idx_inc;
   logic [TMR_W-1:0]      tmr;

   logic       load_go;
   logic       issue_fire;
   logic       enter_done;
   logic       enter_fail;
   logic [1:0] fail_code;
   logic       accept_en;
   logic       accept;
   logic       strobe_fall;
   logic [ADDR_W-1:0] byte_addr;

   // Bytes are only taken while streaming a sector that is not yet full
   assign accept_en = (state == ST_STREAM) && (byte_idx != BYTE_IDX_W'(SECTOR_BYTES));
   assign accept    = accept_en & strobe_fall;
   assign byte_addr = (ADDR_W'(sec_idx) << 9) + ADDR_W'(byte_idx);

   sd_strobe_edge u_strobe (
      .clk      (clk),
      .rst      (rst),
      .strobe_n (sd_wr_n),
      .enable   (accept_en),
      .data_in  (sd_data),
      .fall     (strobe_fall),
      .pulse    (ram_we),
      .data_q   (ram_data)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Next-state logic and the one-cycle control strobes derived from it
   always_comb begin
      state_d      = state;
      load_go      = 1'b0;
      issue_fire   = 1'b0;
      fail_code    = ERR_NONE;
      byte_idx_inc = byte_idx + BYTE_IDX_W'(accept);
      unique case (state)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (start) begin
               load_go = 1'b1;
               state_d = (num_sectors == 8'd0) ? ST_DONE : ST_WAIT_INIT;
            end
         end
         ST_WAIT_INIT: begin
            if (!sd_busy) begin
               if (sd_initialized) begin
                  state_d = ST_ISSUE;
               end else begin
                  state_d   = ST_FAIL;
                  fail_code = ERR_INIT;
               end
            end else if (tmr == TMR_W'(INIT_TOUT - 1)) begin
               state_d   = ST_FAIL;
               fail_code = ERR_INIT;
            end
         end
         ST_ISSUE: begin
            if (!sd_busy) begin
               issue_fire = 1'b1;
               state_d    = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (sd_busy) begin
               state_d = ST_STREAM;
            end else if (tmr == TMR_W'(ACK_TOUT - 1)) begin
               state_d   = ST_FAIL;
               fail_code = ERR_READ;
            end
         end
         ST_STREAM: begin
            if (!sd_busy) begin
               if (!sd_initialized) begin
                  state_d   = ST_FAIL;
                  fail_code = ERR_READ;
               end else if (byte_idx_inc != BYTE_IDX_W'(SECTOR_BYTES)) begin
                  state_d   = ST_FAIL;
                  fail_code = ERR_SHORT;
               end else begin
                  state_d = ST_NEXT;
               end
            end
         end
         ST_NEXT: begin
            if (({1'b0, sec_idx} + 9'd1) == {1'b0, num_q}) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      enter_done = (state_d == ST_DONE) && ((state != ST_DONE) || load_go);
      enter_fail = (state_d == ST_FAIL) && (state != ST_FAIL);
   end

   // Wait-state timer restarts whenever the FSM changes state
   always_ff @(posedge clk) begin
      if (rst) begin
         tmr <= '0;
      end else if (state_d != state) begin
         tmr <= '0;
      end else if ((state == ST_WAIT_INIT) || (state == ST_WAIT_ACK)) begin
         tmr <= tmr + TMR_W'(1);
      end
   end

   // Load bookkeeping, status flags, sector requests and RAM addressing
   always_ff @(posedge clk) begin
      if (rst) begin
         base_q         <= 32'd0;
         num_q          <= 8'd0;
         sec_idx        <= 8'd0;
         byte_idx       <= '0;
         loading        <= 1'b0;
         done           <= 1'b0;
         error_code     <= ERR_NONE;
         sd_sector_addr <= 32'd0;
         sd_start_read  <= 1'b0;
         ram_addr       <= '0;
      end else begin
         sd_start_read <= issue_fire;
         if (load_go) begin
            base_q     <= base_sector;
            num_q      <= num_sectors;
            sec_idx    <= 8'd0;
            byte_idx   <= '0;
            loading    <= 1'b1;
            done       <= 1'b0;
            error_code <= ERR_NONE;
         end
         if (enter_done) begin
            done    <= 1'b1;
            loading <= 1'b0;
         end
         if (enter_fail) begin
            loading    <= 1'b0;
            error_code <= fail_code;
         end
         if (issue_fire) begin
            sd_sector_addr <= base_q + 32'(sec_idx);
         end
         if (accept) begin
            ram_addr <= byte_addr;
            byte_idx <= byte_idx_inc;
         end
         if (state == ST_NEXT) begin
            sec_idx  <= sec_idx + 8'd1;
            byte_idx <= '0;
         end
      end
   end

`ifdef SD_LOADER_CHECKSUM_EN
   logic [7:0] checksum_q;

   // Running modulo-256 sum of every byte written to cartridge RAM
   always_ff @(posedge clk) begin
      if (rst) begin
         checksum_q <= 8'h00;
      end else if (load_go) begin
         checksum_q <= 8'h00;
      end else if (ram_we) begin
         checksum_q <= checksum_q + ram_data;
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_sd_rom_loader.sv
// Scoreboard testbench for sd_rom_loader with a behavioural SD reader model.
module tb_sd_rom_loader;

   localparam int TB_ADDR_W    = 10;
   localparam int TB_INIT_TOUT = 64;

   logic                 clk;
   logic                 rst;
   logic                 start;
   logic [31:0]          base_sector;
   logic [7:0]           num_sectors;
   logic                 sd_busy;
   logic                 sd_initialized;
   logic [7:0]           sd_data;
   logic                 sd_wr_n;
   logic [31:0]          sd_sector_addr;
   logic                 sd_start_read;
   logic [TB_ADDR_W-1:0] ram_addr;
   logic [7:0]           ram_data;
   logic                 ram_we;
   logic                 loading;
   logic                 done;
   logic [1:0]           error_code;
   logic [7:0]           checksum;

   typedef struct {
      logic [TB_ADDR_W-1:0] addr;
      logic [7:0]           data;
      longint               cyc;
   } wr_t;

   wr_t         wr_q[$];
   logic [31:0] sec_q[$];
   wr_t         wrExp;
   logic [31:0] secExp;
   int          checks;
   int          errors;
   int          weCount;
   int          reqCount;
   longint      cycle;

   sd_rom_loader #(
      .ADDR_W    (TB_ADDR_W),
      .INIT_TOUT (TB_INIT_TOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .base_sector    (base_sector),
      .num_sectors    (num_sectors),
      .sd_busy        (sd_busy),
      .sd_initialized (sd_initialized),
      .sd_data        (sd_data),
      .sd_wr_n        (sd_wr_n),
      .sd_sector_addr (sd_sector_addr),
      .sd_start_read  (sd_start_read),
      .ram_addr       (ram_addr),
      .ram_data       (ram_data),
      .ram_we         (ram_we),
      .loading        (loading),
      .done           (done),
      .error_code     (error_code),
      .checksum       (checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle count used to check write latency
   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Image byte for sector s, offset j under a given data pattern
   function automatic logic [7:0] patByte(input int pattern, input int s, input int j);
      case (pattern)
         1:       return 8'(((s * 512) + j) % (1 << TB_ADDR_W));
         2:       return 8'h01;
         3:       return 8'(j);
         4:       return 8'h03;
         5:       return (j == 0) ? 8'hFF : 8'h00;
         default: return 8'($urandom);
      endcase
   endfunction

   // Monitor: pops expected writes and sector requests as the DUT emits them
   always @(negedge clk) begin
      if (ram_we) begin
         weCount++;
         checkOutput("ram_we expected", 64'(wr_q.size() != 0), 64'd1);
         if (wr_q.size() != 0) begin
            wrExp = wr_q.pop_front();
            checkOutput("ram_addr", 64'(ram_addr), 64'(wrExp.addr));
            checkOutput("ram_data", 64'(ram_data), 64'(wrExp.data));
            checkOutput("ram_we latency", 64'(cycle), 64'(wrExp.cyc));
         end
      end
      if (sd_start_read) begin
         reqCount++;
         checkOutput("sd_start_read expected", 64'(sec_q.size() != 0), 64'd1);
         if (sec_q.size() != 0) begin
            secExp = sec_q.pop_front();
            checkOutput("sd_sector_addr", 64'(sd_sector_addr), 64'(secExp));
         end
      end
   end

   task automatic waitFinished();
      for (int k = 0; k < 60; k++) begin
         if (done || (error_code != 2'b00)) break;
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
   endtask

   // endMode: 0 busy falls after last byte, 1 with last byte, 2 with last byte and init lost
   task automatic applyStimulus(input logic [31:0] base, input int num, input int pattern,
                                input int nbytes, input int endMode, input logic [1:0] expErr);
      logic [7:0] csum;
      logic [7:0] d;
      bit         ok;
      int         reqBase;
      csum = 8'h00;
      wr_q.delete();
      sec_q.delete();
      sec_q.push_back(base);
      reqBase     = reqCount;
      base_sector = base;
      num_sectors = 8'(num);
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int s = 0; s < num; s++) begin
         ok = 1'b0;
         for (int k = 0; k < 40; k++) begin
            if (reqCount >= reqBase + s + 1) begin
               ok = 1'b1;
               break;
            end
            @(negedge clk);
         end
         checkOutput("sector request seen", 64'(ok), 64'd1);
         if (!ok) return;
         repeat ($urandom_range(1, 3)) @(negedge clk);
         sd_busy = 1'b1;
         @(negedge clk);
         for (int j = 0; j < nbytes; j++) begin
            d       = patByte(pattern, s, j);
            sd_data = d;
            sd_wr_n = 1'b0;
            if (j < 512) begin
               wr_q.push_back('{addr: TB_ADDR_W'(((s * 512) + j) % (1 << TB_ADDR_W)), data: d, cyc: cycle + 1});
               csum = csum + d;
            end
            if ((j == nbytes - 1) && (endMode != 0)) begin
               sd_busy = 1'b0;
               if (endMode == 2) sd_initialized = 1'b0;
               if (s < num - 1) sec_q.push_back(base + 32'(s + 1));
            end
            @(negedge clk);
            sd_wr_n = 1'b1;
            sd_data = 8'($urandom);
            repeat ($urandom_range(1, 2)) @(negedge clk);
         end
         if (endMode == 0) begin
            if (s < num - 1) sec_q.push_back(base + 32'(s + 1));
            sd_busy = 1'b0;
         end
      end
      waitFinished();
      checkOutput("done", 64'(done), 64'(expErr == 2'b00));
      checkOutput("error_code", 64'(error_code), 64'(expErr));
      checkOutput("loading", 64'(loading), 64'd0);
`ifdef SD_LOADER_CHECKSUM_EN
      checkOutput("checksum", 64'(checksum), 64'(csum));
`else
      checkOutput("checksum", 64'(checksum), 64'd0);
`endif
      checkOutput("pending writes", 64'(wr_q.size()), 64'd0);
      checkOutput("pending requests", 64'(sec_q.size()), 64'd0);
      sd_initialized = 1'b1;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " sd_start_read"}, 64'(sd_start_read), 64'd0);
      checkOutput({tag, " ram_we"}, 64'(ram_we), 64'd0);
      checkOutput({tag, " loading"}, 64'(loading), 64'd0);
      checkOutput({tag, " done"}, 64'(done), 64'd0);
      checkOutput({tag, " error_code"}, 64'(error_code), 64'd0);
      checkOutput({tag, " checksum"}, 64'(checksum), 64'd0);
      checkOutput({tag, " ram_addr"}, 64'(ram_addr), 64'd0);
      checkOutput({tag, " ram_data"}, 64'(ram_data), 64'd0);
      checkOutput({tag, " sd_sector_addr"}, 64'(sd_sector_addr), 64'd0);
   endtask

   // Runs a load that should fail before streaming and checks the error code
   task automatic expectEarlyFail(input string tag, input logic [1:0] expErr, input int bound, output int latency);
      latency = -1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < bound; k++) begin
         if (error_code != 2'b00) begin
            latency = k;
            break;
         end
         @(negedge clk);
      end
      checkOutput({tag, " error_code"}, 64'(error_code), 64'(expErr));
      checkOutput({tag, " loading"}, 64'(loading), 64'd0);
      checkOutput({tag, " done"}, 64'(done), 64'd0);
   endtask

   // Watchdog so a stuck DUT cannot hang the run
   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      int wc;
      logic [31:0] rbase;
      checks = 0; errors = 0; weCount = 0; reqCount = 0; cycle = 0;
      rst = 1'b1; start = 1'b0; base_sector = 32'd0; num_sectors = 8'd0;
      sd_busy = 1'b0; sd_initialized = 1'b1; sd_data = 8'h00; sd_wr_n = 1'b1;
      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] two-sector load at 0x100");
      applyStimulus(32'h100, 2, 1, 512, 0, 2'b00);

      $display("[TB] randomized loads");
      applyStimulus(32'hFFFF_FFFF, 2, 0, 512, 1, 2'b00);
      for (int r = 0; r < 3; r++) begin
         rbase = $urandom;
         applyStimulus(rbase, $urandom_range(1, 3), 0, ($urandom_range(0, 1) == 1) ? 515 : 512,
                       $urandom_range(0, 1), 2'b00);
      end

      $display("[TB] zero-sector load");
      sec_q.delete();
      num_sectors = 8'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checkOutput("zero load done", 64'(done), 64'd1);
      checkOutput("zero load loading", 64'(loading), 64'd0);
      checkOutput("zero load error_code", 64'(error_code), 64'd0);

      $display("[TB] init failure and timeout");
      num_sectors = 8'd1;
      sd_initialized = 1'b0;
      expectEarlyFail("init fail", 2'b01, 20, lat);
      sd_busy = 1'b1;
      expectEarlyFail("init timeout", 2'b01, TB_INIT_TOUT + 40, lat);
      checkOutput("init timeout latency", 64'((lat >= TB_INIT_TOUT - 2) && (lat <= TB_INIT_TOUT + 2)), 64'd1);
      sd_busy = 1'b0;
      sd_initialized = 1'b1;

      $display("[TB] acknowledge timeout");
      base_sector = 32'h0000_2000;
      sec_q.delete();
      sec_q.push_back(32'h0000_2000);
      expectEarlyFail("ack timeout", 2'b10, 60, lat);
      checkOutput("ack timeout requests", 64'(sec_q.size()), 64'd0);

      $display("[TB] short sector and read failure");
      wc = weCount;
      applyStimulus(32'h40, 1, 0, 300, 0, 2'b11);
      checkOutput("short sector writes", 64'(weCount - wc), 64'd300);
      applyStimulus(32'h80, 1, 0, 512, 2, 2'b10);

      $display("[TB] checksum patterns");
      applyStimulus(32'h10, 1, 2, 512, 0, 2'b00);
      applyStimulus(32'h11, 1, 3, 512, 0, 2'b00);
      applyStimulus(32'h12, 1, 4, 512, 1, 2'b00);
      applyStimulus(32'h13, 1, 5, 512, 0, 2'b00);

      $display("[TB] reset mid-sector");
      wr_q.delete();
      sec_q.delete();
      sec_q.push_back(32'h500);
      wc = reqCount;
      base_sector = 32'h500;
      num_sectors = 8'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (reqCount > wc) break;
         @(negedge clk);
      end
      checkOutput("reset test request", 64'(reqCount - wc), 64'd1);
      sd_busy = 1'b1;
      @(negedge clk);
      for (int j = 0; j < 100; j++) begin
         sd_data = 8'($urandom);
         sd_wr_n = 1'b0;
         wr_q.push_back('{addr: TB_ADDR_W'(j), data: sd_data, cyc: cycle + 1});
         @(negedge clk);
         sd_wr_n = 1'b1;
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      checkOutput("writes before reset", 64'(wr_q.size()), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      checkResetOutputs("mid-sector reset");
      rst = 1'b0;
      wc = weCount;
      for (int j = 0; j < 20; j++) begin
         sd_wr_n = 1'b0;
         @(negedge clk);
         sd_wr_n = 1'b1;
         @(negedge clk);
      end
      sd_busy = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("ram_we after reset", 64'(weCount - wc), 64'd0);
      checkOutput("loading after reset", 64'(loading), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
